// File: rtl/jesd204b_tx_pkg.sv
// Shared constants and types for the JESD204B transmit lane sequencer.
package jesd204b_tx_pkg;

  // Control characters (pre-8b/10b octet values, sent with K=1)
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows

  // Initial lane alignment sequence shape
  localparam int unsigned ILAS_MULTIFRAMES = 4;
  localparam int unsigned CFG_OCTETS       = 14;
  localparam int unsigned CFG_WIDTH        = CFG_OCTETS * 8;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } lane_state_e;

endpackage

// File: rtl/jesd204b_ilas_octet.sv
// Combinational ILAS octet generator for one octet position j of multiframe m.
module jesd204b_ilas_octet
  import jesd204b_tx_pkg::*;
#(
  parameter int unsigned FK_OCTETS = 64,
  parameter int unsigned J_W       = 6
) (
  input  logic [1:0]           m_i,
  input  logic [J_W-1:0]       j_i,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  output logic [7:0]           octet_o,
  output logic                 is_k_o
);

  // Priority: /R/, /A/, then the /Q/ + config block of multiframe 1, else ramp
  always_comb begin
    octet_o = 8'(j_i);
    is_k_o  = 1'b0;
    if (j_i == '0) begin
      octet_o = K28_0;
      is_k_o  = 1'b1;
    end else if (j_i == J_W'(FK_OCTETS - 1)) begin
      octet_o = K28_3;
      is_k_o  = 1'b1;
    end else if (m_i == 2'd1) begin
      if (j_i == J_W'(1)) begin
        octet_o = K28_4;
        is_k_o  = 1'b1;
      end else begin
        for (int n = 0; n < int'(CFG_OCTETS); n++) begin
          if (j_i == J_W'(n + 2)) octet_o = cfg_i[n*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/jesd204b_tx_lane_seq.sv
// JESD204B transmit lane sequencer: CGS while SYNC~ is low, LMFC-aligned
// 4-multiframe ILAS after release, then registered user data.
module jesd204b_tx_lane_seq
  import jesd204b_tx_pkg::*;
#(
  parameter int unsigned PARALLEL_OCTETS = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned F_OCTETS        = 2,
  parameter int unsigned K_FRAMES        = 32,
  parameter int unsigned RESYNC_CYCLES   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sync_ni,
  input  logic                       sysref_i,
  input  logic [CFG_WIDTH-1:0]       ilas_cfg_i,
  input  logic [DATA_WIDTH-1:0]      tx_data_i,
  output logic                       tx_ready_o,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [PARALLEL_OCTETS-1:0] out_char_is_k_o,
  output logic                       lmfc_o,
  output logic                       sync_err_o
);

  localparam int unsigned FK       = F_OCTETS * K_FRAMES;
  localparam int unsigned MF_BEATS = FK / PARALLEL_OCTETS;
  localparam int unsigned CNT_W    = (MF_BEATS > 1) ? $clog2(MF_BEATS) : 1;
  localparam int unsigned J_W      = $clog2(FK);
  localparam int unsigned LOW_W    = $clog2(RESYNC_CYCLES + 1);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MF_BEATS - 1);
  localparam logic [LOW_W-1:0]      LOW_MAX  = LOW_W'(RESYNC_CYCLES);
  localparam logic [1:0]            MF_LAST  = 2'(ILAS_MULTIFRAMES - 1);
  localparam logic [DATA_WIDTH-1:0] CGS_WORD = DATA_WIDTH'({PARALLEL_OCTETS{K28_5}});

  lane_state_e                state_q, state_d;
  logic [CNT_W-1:0]           lmfc_cnt_q, lmfc_cnt_d;
  logic [1:0]                 mf_idx_q, mf_idx_d;
  logic [LOW_W-1:0]           low_cnt_q, low_cnt_d;
  logic                       sysref_q;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [PARALLEL_OCTETS-1:0] out_k_q, out_k_d;
  logic                       tx_ready_q, tx_ready_d;
  logic                       lmfc_q, lmfc_d;
  logic                       sync_err_q, sync_err_d;

  logic [DATA_WIDTH-1:0]      ilas_data;
  logic [PARALLEL_OCTETS-1:0] ilas_k;
  logic                       sysref_rise;

  assign sysref_rise = sysref_i & ~sysref_q;

  // One ILAS generator per parallel octet; during ILAS the beat index is lmfc_cnt
  for (genvar g = 0; g < PARALLEL_OCTETS; g++) begin : g_octet
    logic [J_W-1:0] j_pos;
    assign j_pos = J_W'(int'(lmfc_cnt_q) * int'(PARALLEL_OCTETS) + g);

    jesd204b_ilas_octet #(
      .FK_OCTETS (FK),
      .J_W       (J_W)
    ) u_octet (
      .m_i     (mf_idx_q),
      .j_i     (j_pos),
      .cfg_i   (ilas_cfg_i),
      .octet_o (ilas_data[g*8 +: 8]),
      .is_k_o  (ilas_k[g])
    );
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CGS;
      lmfc_cnt_q <= '0;
      mf_idx_q   <= '0;
      low_cnt_q  <= '0;
      sysref_q   <= 1'b0;
      out_data_q <= CGS_WORD;
      out_k_q    <= '1;
      tx_ready_q <= 1'b0;
      lmfc_q     <= 1'b1;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lmfc_cnt_q <= lmfc_cnt_d;
      mf_idx_q   <= mf_idx_d;
      low_cnt_q  <= low_cnt_d;
      sysref_q   <= sysref_i;
      out_data_q <= out_data_d;
      out_k_q    <= out_k_d;
      tx_ready_q <= tx_ready_d;
      lmfc_q     <= lmfc_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state, LMFC, SYNC~ monitor and next output word
  always_comb begin
    state_d    = state_q;
    lmfc_cnt_d = (lmfc_cnt_q == CNT_LAST) ? '0 : lmfc_cnt_q + CNT_W'(1);
    mf_idx_d   = mf_idx_q;
    low_cnt_d  = low_cnt_q;
    sync_err_d = 1'b0;
    out_data_d = CGS_WORD;
    out_k_d    = '1;

    case (state_q)
      CGS: begin
        low_cnt_d = '0;
        mf_idx_d  = '0;
        if (sysref_rise) lmfc_cnt_d = '0;
        if (sync_ni && (lmfc_cnt_q == CNT_LAST)) state_d = ILAS;
      end
      ILAS: begin
        out_data_d = ilas_data;
        out_k_d    = ilas_k;
        if (lmfc_cnt_q == CNT_LAST) begin
          mf_idx_d = mf_idx_q + 2'd1;
          if (mf_idx_q == MF_LAST) state_d = DATA;
        end
      end
      DATA: begin
        out_data_d = tx_data_i;
        out_k_d    = '0;
      end
      default: state_d = CGS;
    endcase

    // A long SYNC~ low overrides any ILAS progress; a short one is only reported
    if (state_q != CGS) begin
      if (!sync_ni) begin
        if (low_cnt_q != LOW_MAX) low_cnt_d = low_cnt_q + LOW_W'(1);
        if (low_cnt_d == LOW_MAX) begin
          state_d  = CGS;
          mf_idx_d = '0;
        end
      end else begin
        sync_err_d = (low_cnt_q != '0) && (low_cnt_q < LOW_MAX);
        low_cnt_d  = '0;
      end
    end

    tx_ready_d = (state_d == DATA);
    lmfc_d     = (lmfc_cnt_d == '0);
  end

  assign tx_ready_o      = tx_ready_q;
  assign out_data_o      = out_data_q;
  assign out_char_is_k_o = out_k_q;
  assign lmfc_o          = lmfc_q;
  assign sync_err_o      = sync_err_q;

endmodule

// File: tb/tb_jesd204b_tx_lane_seq.sv
// Bench for jesd204b_tx_lane_seq: cycle model of the lane stream plus
// literal checks on the key words of the sequence.
module tb_jesd204b_tx_lane_seq;

  localparam int P   = 4;
  localparam int FK  = 64;
  localparam int MFB = 16;
  localparam int RES = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sync_n = 1'b0;
  logic         sysref = 1'b0;
  logic [111:0] cfg;
  logic [31:0]  txd = 32'hA5A5_0000;
  logic         tx_ready_o;
  logic [31:0]  out_data_o;
  logic [3:0]   out_char_is_k_o;
  logic         lmfc_o;
  logic         sync_err_o;

  int n_vec = 0;
  int n_err = 0;
  int dcnt  = 0;
  bit run   = 1'b0;

  // Model state: mode 0=CGS 1=ILAS 2=DATA, b = ILAS beat 0..63
  int          m_mode = 0;
  int          m_lmfc = 0;
  int          m_b    = 0;
  int          m_low  = 0;
  bit          m_prev = 1'b0;
  logic [31:0] e_data = 32'hBCBC_BCBC;
  logic [3:0]  e_k    = 4'hF;
  bit          e_ready = 1'b0;
  bit          e_lmfc  = 1'b1;
  bit          e_err   = 1'b0;

  jesd204b_tx_lane_seq #(
    .PARALLEL_OCTETS (4),
    .DATA_WIDTH      (32),
    .F_OCTETS        (2),
    .K_FRAMES        (32),
    .RESYNC_CYCLES   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sync_ni         (sync_n),
    .sysref_i        (sysref),
    .ilas_cfg_i      (cfg),
    .tx_data_i       (txd),
    .tx_ready_o      (tx_ready_o),
    .out_data_o      (out_data_o),
    .out_char_is_k_o (out_char_is_k_o),
    .lmfc_o          (lmfc_o),
    .sync_err_o      (sync_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ILAS octet for absolute ILAS beat b and lane l; returns {K, octet}
  function automatic logic [8:0] ilas_oct(input int b, input int l);
    int m;
    int j;
    m = b / MFB;
    j = (b % MFB) * P + l;
    if (j == 0)                      return {1'b1, 8'h1C};
    if (j == FK - 1)                 return {1'b1, 8'h7C};
    if (m == 1 && j == 1)            return {1'b1, 8'h9C};
    if (m == 1 && j >= 2 && j <= 15) return {1'b0, cfg[(j-2)*8 +: 8]};
    return {1'b0, 8'(j)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lmfc = 0; m_b = 0; m_low = 0; m_prev = 1'b0;
    e_data = 32'hBCBC_BCBC; e_k = 4'hF; e_ready = 1'b0; e_lmfc = 1'b1; e_err = 1'b0;
  endtask

  // Advance the model across the next clock edge using the current inputs
  task automatic model_step();
    logic [31:0] nd;
    logic [3:0]  nk;
    logic [8:0]  o;
    bit          rise;
    int          nmode;
    rise   = sysref && !m_prev;
    m_prev = sysref;
    nd     = 32'hBCBC_BCBC;
    nk     = 4'hF;
    e_err  = 1'b0;
    nmode  = m_mode;
    if (m_mode == 1) begin
      for (int l = 0; l < P; l++) begin
        o = ilas_oct(m_b, l);
        nd[l*8 +: 8] = o[7:0];
        nk[l] = o[8];
      end
    end else if (m_mode == 2) begin
      nd = txd;
      nk = 4'h0;
    end
    if (m_mode == 0) begin
      m_low = 0;
      if (sync_n && m_lmfc == MFB - 1) begin
        nmode = 1;
        m_b = 0;
      end
      m_lmfc = rise ? 0 : (m_lmfc + 1) % MFB;
    end else begin
      m_lmfc = (m_lmfc + 1) % MFB;
      if (!sync_n) m_low = (m_low < RES) ? m_low + 1 : RES;
      else begin
        e_err = (m_low > 0 && m_low < RES);
        m_low = 0;
      end
      if (m_low == RES) nmode = 0;
      else if (m_mode == 1) begin
        if (m_b == 4 * MFB - 1) nmode = 2;
        else m_b++;
      end
    end
    m_mode  = nmode;
    e_data  = nd;
    e_k     = nk;
    e_ready = (m_mode == 2);
    e_lmfc  = (m_lmfc == 0);
  endtask

  // Every-cycle comparison against the model, on the inactive edge
  always @(negedge clk) begin
    if (run) begin
      if (rst) model_reset();
      check("cyc_data",  out_data_o,              e_data);
      check("cyc_k",     32'(out_char_is_k_o),    32'(e_k));
      check("cyc_ready", 32'(tx_ready_o),         32'(e_ready));
      check("cyc_lmfc",  32'(lmfc_o),             32'(e_lmfc));
      check("cyc_err",   32'(sync_err_o),         32'(e_err));
      if (!rst) model_step();
    end
  end

  // One clock; data word advances only after being consumed
  task automatic tick();
    logic c;
    c = tx_ready_o;
    @(posedge clk);
    #1;
    if (c) dcnt++;
    txd = 32'hA5A5_0000 + 32'(dcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < 14; n++) cfg[n*8 +: 8] = 8'(192 + n);
    #1 rst = 1'b1;
    #1 run = 1'b1;
    check("rst_data",  out_data_o,           32'hBCBC_BCBC);
    check("rst_k",     32'(out_char_is_k_o), 32'hF);
    check("rst_ready", 32'(tx_ready_o),      32'h0);
    check("rst_lmfc",  32'(lmfc_o),          32'h1);
    check("rst_err",   32'(sync_err_o),      32'h0);
    repeat (3) tick();
    rst = 1'b0;

    repeat (100) tick();
    check("cgs_data",  out_data_o,           32'hBCBC_BCBC);
    check("cgs_k",     32'(out_char_is_k_o), 32'hF);
    check("cgs_ready", 32'(tx_ready_o),      32'h0);

    // SYSREF realigns LMFC in CGS
    for (int i = 0; i < 20; i++) begin
      if (lmfc_o) break;
      tick();
    end
    check("wait_lmfc", 32'(lmfc_o), 32'h1);
    repeat (7) tick();
    sysref = 1'b1;
    check("sysref_pre_lmfc", 32'(lmfc_o), 32'h0);
    tick();
    sysref = 1'b0;
    check("sysref_cgs_lmfc", 32'(lmfc_o), 32'h1);

    // Release SYNC~ mid-multiframe
    repeat (5) tick();
    sync_n = 1'b1;
    repeat (10) tick();
    check("cgs_hold_k", 32'(out_char_is_k_o), 32'hF);
    tick();
    check("ilas_lmfc",      32'(lmfc_o),     32'h1);
    check("ilas_pre_data",  out_data_o,      32'hBCBC_BCBC);
    tick();
    check("ilas_b0_data",   out_data_o,           32'h0302_011C);
    check("ilas_b0_k",      32'(out_char_is_k_o), 32'h1);
    repeat (15) tick();
    check("ilas_b15_data",  out_data_o,           32'h7C3E_3D3C);
    check("ilas_b15_k",     32'(out_char_is_k_o), 32'h8);
    tick();
    check("mf1_b0_data",    out_data_o,           32'hC1C0_9C1C);
    check("mf1_b0_k",       32'(out_char_is_k_o), 32'h3);
    repeat (47) tick();
    check("ilas_last_data", out_data_o,           32'h7C3E_3D3C);
    check("ilas_last_k",    32'(out_char_is_k_o), 32'h8);
    check("ilas_last_rdy",  32'(tx_ready_o),      32'h1);
    check("ilas_last_lmfc", 32'(lmfc_o),          32'h1);
    tick();
    check("data0",          out_data_o,           32'hA5A5_0000);
    check("data0_k",        32'(out_char_is_k_o), 32'h0);

    // SYSREF ignored in DATA
    repeat (3) tick();
    sysref = 1'b1;
    tick();
    sysref = 1'b0;
    check("sysref_data_lmfc", 32'(lmfc_o), 32'h0);
    repeat (11) tick();
    check("data_lmfc_keep",   32'(lmfc_o), 32'h1);

    // Short SYNC~ low: error pulse only
    sync_n = 1'b0;
    tick();
    tick();
    sync_n = 1'b1;
    tick();
    check("short_err",   32'(sync_err_o), 32'h1);
    check("short_ready", 32'(tx_ready_o), 32'h1);
    tick();
    check("short_err_end", 32'(sync_err_o), 32'h0);

    // Long SYNC~ low: resync to CGS
    sync_n = 1'b0;
    tick();
    tick();
    tick();
    check("long_ready_d", 32'(tx_ready_o), 32'h1);
    tick();
    check("long_ready_e", 32'(tx_ready_o), 32'h0);
    tick();
    check("resync_data",  out_data_o,           32'hBCBC_BCBC);
    check("resync_k",     32'(out_char_is_k_o), 32'hF);
    repeat (5) tick();

    // Second ILAS, interrupted by reset at beat 20
    sync_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_char_is_k_o == 4'h1) break;
      tick();
    end
    check("ilas2_b0_k",    32'(out_char_is_k_o), 32'h1);
    check("ilas2_b0_data", out_data_o,           32'h0302_011C);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("rstmid_data",  out_data_o,           32'hBCBC_BCBC);
    check("rstmid_k",     32'(out_char_is_k_o), 32'hF);
    check("rstmid_ready", 32'(tx_ready_o),      32'h0);
    check("rstmid_lmfc",  32'(lmfc_o),          32'h1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_char_is_k_o == 4'h1) break;
      tick();
    end
    check("ilas3_b0_k",    32'(out_char_is_k_o), 32'h1);
    check("ilas3_b0_data", out_data_o,           32'h0302_011C);
    repeat (16) tick();
    check("ilas3_mf1_k",    32'(out_char_is_k_o), 32'h3);
    check("ilas3_mf1_data", out_data_o,           32'hC1C0_9C1C);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
